// File: rtl/prog_mem_arbiter_pkg.sv
// Shared definitions for the program-memory arbiter: width macros,
// response-owner encoding and read-requester indices.
`ifndef COMMAND_WIDTH
`define COMMAND_WIDTH 32
`endif
`ifndef PROGRAM_MEM_SIZE
`define PROGRAM_MEM_SIZE 1024
`endif

package prog_mem_arbiter_pkg;

    // Who owns the read data returning from the RAM this cycle.
    typedef enum logic [1:0] {
        RSP_NONE  = 2'd0,
        RSP_FETCH = 2'd1,
        RSP_DBG   = 2'd2
    } rsp_owner_e;

    // Bit positions of the two readers in the round-robin request vector.
    localparam int unsigned RD_FETCH = 0;
    localparam int unsigned RD_DBG   = 1;

endpackage

// File: rtl/prog_mem_arbiter_if.sv
// Bus bundle between the arbiter and its environment (programmer, CPU,
// debug unit, RAM). slave = arbiter side, master = environment side.
interface prog_mem_arbiter_if #(
    parameter int DATA_WIDTH = `COMMAND_WIDTH,
    parameter int ADDR_WIDTH = $clog2(`PROGRAM_MEM_SIZE)
);
    logic                  in_clke;
    logic                  in_cpu_en;
    logic                  in_flash_signal;
    logic [DATA_WIDTH-1:0] in_flash_command;
    logic [ADDR_WIDTH-1:0] in_flash_addr;
    logic                  in_fetch_req;
    logic [ADDR_WIDTH-1:0] in_fetch_addr;
    logic                  out_fetch_gnt;
    logic                  out_fetch_valid;
    logic [DATA_WIDTH-1:0] out_fetch_data;
    logic                  in_dbg_req;
    logic [ADDR_WIDTH-1:0] in_dbg_addr;
    logic                  out_dbg_gnt;
    logic                  out_dbg_valid;
    logic [DATA_WIDTH-1:0] out_dbg_data;
    logic                  out_mem_en;
    logic                  out_mem_we;
    logic [ADDR_WIDTH-1:0] out_mem_addr;
    logic [DATA_WIDTH-1:0] out_mem_wdata;
    logic [DATA_WIDTH-1:0] in_mem_rdata;
    logic [ADDR_WIDTH:0]   out_wr_count;

    modport slave (
        input  in_clke, in_cpu_en, in_flash_signal, in_flash_command, in_flash_addr,
        input  in_fetch_req, in_fetch_addr, in_dbg_req, in_dbg_addr, in_mem_rdata,
        output out_fetch_gnt, out_fetch_valid, out_fetch_data,
        output out_dbg_gnt, out_dbg_valid, out_dbg_data,
        output out_mem_en, out_mem_we, out_mem_addr, out_mem_wdata, out_wr_count
    );

    modport master (
        output in_clke, in_cpu_en, in_flash_signal, in_flash_command, in_flash_addr,
        output in_fetch_req, in_fetch_addr, in_dbg_req, in_dbg_addr, in_mem_rdata,
        input  out_fetch_gnt, out_fetch_valid, out_fetch_data,
        input  out_dbg_gnt, out_dbg_valid, out_dbg_data,
        input  out_mem_en, out_mem_we, out_mem_addr, out_mem_wdata, out_wr_count
    );
endinterface

// File: rtl/prog_mem_rr_arb2.sv
// Two-requester round-robin arbiter. On a tie the requester that was not
// granted last wins; the last-grant register resets to requester 1.
module prog_mem_rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);
    logic r_last;   // 1: requester 1 was granted last

    // Grant selection for the current cycle.
    always_comb begin
        o_gnt = '0;
        if (i_en) begin
            if (i_req[0] && (!i_req[1] || r_last)) begin
                o_gnt[0] = 1'b1;
            end else if (i_req[1]) begin
                o_gnt[1] = 1'b1;
            end
        end
    end

    // Remember which requester won the most recent grant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= 1'b1;
        end else if (|o_gnt) begin
            r_last <= o_gnt[1];
        end
    end
endmodule

// File: rtl/prog_mem_arbiter.sv
// Single-port program RAM arbiter: buffered flash writes take priority,
// CPU fetch and debug reads share the remaining slots round-robin.
module prog_mem_arbiter
    import prog_mem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = `COMMAND_WIDTH,
    parameter int ADDR_WIDTH = $clog2(`PROGRAM_MEM_SIZE)
) (
    input  logic                in_clk,
    input  logic                in_rst_n,
    prog_mem_arbiter_if.slave   bus
);
    logic                  r_pend_valid;
    logic [ADDR_WIDTH-1:0] r_pend_addr;
    logic [DATA_WIDTH-1:0] r_pend_data;
    logic [ADDR_WIDTH:0]   r_wr_count;
    rsp_owner_e            r_rsp_owner;
    rsp_owner_e            w_rsp_owner_nxt;

    logic                  w_active;
    logic                  w_wr_issue;
    logic                  w_rd_en;
    logic [1:0]            w_req;
    logic [1:0]            w_gnt;

    // Reset gates the issue path so every output is quiet while it is held.
    assign w_active   = bus.in_clke & in_rst_n;
    assign w_wr_issue = w_active & r_pend_valid;
    assign w_rd_en    = w_active & ~r_pend_valid;

    assign w_req[RD_FETCH] = bus.in_fetch_req & bus.in_cpu_en;
    assign w_req[RD_DBG]   = bus.in_dbg_req;

    prog_mem_rr_arb2 u_rr (
        .i_clk   (in_clk),
        .i_rst_n (in_rst_n),
        .i_en    (w_rd_en),
        .i_req   (w_req),
        .o_gnt   (w_gnt)
    );

    // Pending-write buffer: a new pulse overrides a same-cycle drain.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_data  <= '0;
        end else if (bus.in_clke && bus.in_flash_signal) begin
            r_pend_valid <= 1'b1;
            r_pend_addr  <= bus.in_flash_addr;
            r_pend_data  <= bus.in_flash_command;
        end else if (w_wr_issue) begin
            r_pend_valid <= 1'b0;
        end
    end

    // Saturating count of writes issued to the RAM.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_wr_count <= '0;
        end else if (w_wr_issue && !(&r_wr_count)) begin
            r_wr_count <= r_wr_count + 1'b1;
        end
    end

    // Response owner register; not clock-enabled so data is never dropped.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_rsp_owner <= RSP_NONE;
        end else begin
            r_rsp_owner <= w_rsp_owner_nxt;
        end
    end

    // Next response owner follows this cycle's read grant.
    always_comb begin
        w_rsp_owner_nxt = RSP_NONE;
        if (w_gnt[RD_FETCH]) begin
            w_rsp_owner_nxt = RSP_FETCH;
        end else if (w_gnt[RD_DBG]) begin
            w_rsp_owner_nxt = RSP_DBG;
        end
    end

    // RAM strobe mux: buffered write first, then the granted reader.
    always_comb begin
        bus.out_mem_en    = 1'b0;
        bus.out_mem_we    = 1'b0;
        bus.out_mem_addr  = '0;
        bus.out_mem_wdata = '0;
        if (w_wr_issue) begin
            bus.out_mem_en    = 1'b1;
            bus.out_mem_we    = 1'b1;
            bus.out_mem_addr  = r_pend_addr;
            bus.out_mem_wdata = r_pend_data;
        end else if (w_gnt[RD_FETCH]) begin
            bus.out_mem_en   = 1'b1;
            bus.out_mem_addr = bus.in_fetch_addr;
        end else if (w_gnt[RD_DBG]) begin
            bus.out_mem_en   = 1'b1;
            bus.out_mem_addr = bus.in_dbg_addr;
        end
    end

    assign bus.out_fetch_gnt   = w_gnt[RD_FETCH];
    assign bus.out_dbg_gnt     = w_gnt[RD_DBG];
    assign bus.out_fetch_valid = (r_rsp_owner == RSP_FETCH);
    assign bus.out_dbg_valid   = (r_rsp_owner == RSP_DBG);
    assign bus.out_fetch_data  = bus.in_mem_rdata;
    assign bus.out_dbg_data    = bus.in_mem_rdata;
    assign bus.out_wr_count    = r_wr_count;
endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Directed bench for prog_mem_arbiter with a behavioural synchronous RAM.
module tb_prog_mem_arbiter;
    localparam int DW = 32;
    localparam int AW = 10;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    prog_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    prog_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: preloaded with A000_0000 + address, one-cycle read latency.
    logic [DW-1:0] ram [1024];
    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'hA000_0000 + i;
        bus.in_mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (bus.out_mem_en) begin
                if (bus.out_mem_we) ram[bus.out_mem_addr] = bus.out_mem_wdata;
                else bus.in_mem_rdata <= ram[bus.out_mem_addr];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        bus.in_clke = 1'b1;
        bus.in_cpu_en = 1'b1;
        bus.in_flash_signal = 1'b0;
        bus.in_flash_command = '0;
        bus.in_flash_addr = '0;
        bus.in_fetch_req = 1'b0;
        bus.in_fetch_addr = '0;
        bus.in_dbg_req = 1'b0;
        bus.in_dbg_addr = '0;

        // Reset state
        sample();
        chk("rst_mem_en", bus.out_mem_en, 0);
        chk("rst_wr_count", bus.out_wr_count, 0);
        chk("rst_fvalid", bus.out_fetch_valid, 0);
        chk("rst_dvalid", bus.out_dbg_valid, 0);
        next(); rst_n = 1'b1;

        // Single flash write: addr 5, DEADBEEF
        next();
        bus.in_flash_signal = 1'b1; bus.in_flash_addr = 10'h005; bus.in_flash_command = 32'hDEAD_BEEF;
        sample();
        chk("wr_pulse_cycle_idle", bus.out_mem_en, 0);
        next(); bus.in_flash_signal = 1'b0;
        sample();
        chk("wr_we", bus.out_mem_we, 1);
        chk("wr_en", bus.out_mem_en, 1);
        chk("wr_addr", bus.out_mem_addr, 10'h005);
        chk("wr_data", bus.out_mem_wdata, 32'hDEAD_BEEF);
        next();
        sample();
        chk("wr_count1", bus.out_wr_count, 1);
        chk("wr_once", bus.out_mem_en, 0);

        // Fetch and debug both held: alternate, fetch first
        next();
        bus.in_fetch_req = 1'b1; bus.in_fetch_addr = 10'h010;
        bus.in_dbg_req = 1'b1; bus.in_dbg_addr = 10'h020;
        sample();
        chk("rr0_fgnt", bus.out_fetch_gnt, 1);
        chk("rr0_dgnt", bus.out_dbg_gnt, 0);
        chk("rr0_addr", bus.out_mem_addr, 10'h010);
        chk("rr0_we", bus.out_mem_we, 0);
        next(); sample();
        chk("rr1_dgnt", bus.out_dbg_gnt, 1);
        chk("rr1_fgnt", bus.out_fetch_gnt, 0);
        chk("rr1_addr", bus.out_mem_addr, 10'h020);
        chk("rr1_fvalid", bus.out_fetch_valid, 1);
        chk("rr1_fdata", bus.out_fetch_data, 32'hA000_0010);
        next(); sample();
        chk("rr2_fgnt", bus.out_fetch_gnt, 1);
        chk("rr2_dvalid", bus.out_dbg_valid, 1);
        chk("rr2_fvalid", bus.out_fetch_valid, 0);
        chk("rr2_ddata", bus.out_dbg_data, 32'hA000_0020);
        next(); sample();
        chk("rr3_dgnt", bus.out_dbg_gnt, 1);
        chk("rr3_fvalid", bus.out_fetch_valid, 1);
        next();
        bus.in_fetch_req = 1'b0; bus.in_dbg_req = 1'b0;
        sample();
        chk("rr4_dvalid", bus.out_dbg_valid, 1);
        chk("rr4_idle", bus.out_mem_en, 0);

        // Flash pulse ahead of a fetch: write first, fetch one cycle later
        next();
        bus.in_flash_signal = 1'b1; bus.in_flash_addr = 10'h006; bus.in_flash_command = 32'h1234_5678;
        sample();
        chk("pri0_dvalid_once", bus.out_dbg_valid, 0);
        next();
        bus.in_flash_signal = 1'b0; bus.in_fetch_req = 1'b1; bus.in_fetch_addr = 10'h011;
        sample();
        chk("pri1_we", bus.out_mem_we, 1);
        chk("pri1_addr", bus.out_mem_addr, 10'h006);
        chk("pri1_fgnt_stall", bus.out_fetch_gnt, 0);
        next(); sample();
        chk("pri2_fgnt", bus.out_fetch_gnt, 1);
        chk("pri2_addr", bus.out_mem_addr, 10'h011);
        next(); bus.in_fetch_req = 1'b0;
        sample();
        chk("pri3_fvalid", bus.out_fetch_valid, 1);
        chk("pri3_fdata", bus.out_fetch_data, 32'hA000_0011);
        chk("pri3_count", bus.out_wr_count, 2);

        // CPU disabled: only debug is granted, debug reads back written word
        next();
        bus.in_cpu_en = 1'b0;
        bus.in_fetch_req = 1'b1; bus.in_fetch_addr = 10'h012;
        bus.in_dbg_req = 1'b1; bus.in_dbg_addr = 10'h005;
        sample();
        chk("cpu0_dgnt", bus.out_dbg_gnt, 1);
        chk("cpu0_fgnt", bus.out_fetch_gnt, 0);
        chk("cpu0_addr", bus.out_mem_addr, 10'h005);
        next(); sample();
        chk("cpu1_dgnt", bus.out_dbg_gnt, 1);
        chk("cpu1_fgnt", bus.out_fetch_gnt, 0);
        chk("cpu1_dvalid", bus.out_dbg_valid, 1);
        chk("cpu1_ddata", bus.out_dbg_data, 32'hDEAD_BEEF);
        next();
        bus.in_cpu_en = 1'b1; bus.in_dbg_req = 1'b0;
        sample();
        chk("cpu2_fgnt", bus.out_fetch_gnt, 1);
        chk("cpu2_addr", bus.out_mem_addr, 10'h012);
        next(); bus.in_fetch_req = 1'b0;
        sample();
        chk("cpu3_fvalid", bus.out_fetch_valid, 1);
        chk("cpu3_fdata", bus.out_fetch_data, 32'hA000_0012);

        // Reset one cycle after a fetch grant, with a write pending
        next();
        bus.in_fetch_req = 1'b1; bus.in_fetch_addr = 10'h013;
        bus.in_flash_signal = 1'b1; bus.in_flash_addr = 10'h007; bus.in_flash_command = 32'h0000_0077;
        sample();
        chk("ar0_fgnt", bus.out_fetch_gnt, 1);
        next();
        bus.in_flash_signal = 1'b0; rst_n = 1'b0;
        sample();
        chk("ar1_fvalid", bus.out_fetch_valid, 0);
        chk("ar1_fgnt", bus.out_fetch_gnt, 0);
        chk("ar1_mem_en", bus.out_mem_en, 0);
        chk("ar1_we", bus.out_mem_we, 0);
        chk("ar1_addr", bus.out_mem_addr, 0);
        chk("ar1_count", bus.out_wr_count, 0);
        next(); sample();
        chk("ar2_fvalid", bus.out_fetch_valid, 0);
        chk("ar2_mem_en", bus.out_mem_en, 0);
        next();
        rst_n = 1'b1; bus.in_fetch_req = 1'b0;
        sample();
        chk("ar3_write_lost", bus.out_mem_en, 0);
        chk("ar3_fvalid", bus.out_fetch_valid, 0);

        // Clock enable 1-of-4, 16 pulses 4 cycles apart
        for (int k = 0; k <= 16; k++) begin
            for (int ph = 0; ph < 4; ph++) begin
                next();
                bus.in_clke = (ph == 0);
                bus.in_flash_signal = (ph == 0) && (k < 16);
                bus.in_flash_addr = 10'(k);
                bus.in_flash_command = 32'hC000_0000 + k;
                sample();
                if (ph == 0) begin
                    if (k == 0) begin
                        chk("ce_first_idle", bus.out_mem_en, 0);
                    end else begin
                        chk("ce_we", bus.out_mem_we, 1);
                        chk("ce_addr", bus.out_mem_addr, 10'(k - 1));
                        chk("ce_data", bus.out_mem_wdata, 32'hC000_0000 + k - 1);
                    end
                end else if (ph == 1) begin
                    chk("ce_gated", bus.out_mem_en, 0);
                end
            end
        end
        chk("ce_count16", bus.out_wr_count, 16);

        // Debug readback of the last word written under clock enable
        next();
        bus.in_clke = 1'b1; bus.in_flash_signal = 1'b0;
        bus.in_dbg_req = 1'b1; bus.in_dbg_addr = 10'h00F;
        sample();
        chk("rb_dgnt", bus.out_dbg_gnt, 1);
        next(); bus.in_dbg_req = 1'b0;
        sample();
        chk("rb_dvalid", bus.out_dbg_valid, 1);
        chk("rb_ddata", bus.out_dbg_data, 32'hC000_000F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
